// File: rtl/ctrl_pipe.sv
// Pipelined RV32I control: ID decode into a control word carried through ID/EX, EX/MEM, MEM/WB.
// Optional macro CTRL_MEXT_EN enables decode of the MUL/DIV family (R-type, funct7=0000001).
module ctrl_pipe #(
  parameter int REG_AW        = 5,
  parameter int LOAD_USE_DIST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              load_use_stall_o,
  output logic              illegal_o,
  output logic              ex_valid_o,
  output logic              ex_alua_src_o,
  output logic              ex_alub_src_o,
  output logic [4:0]        ex_alu_op_o,
  output logic [4:0]        ex_br_op_o,
  output logic [2:0]        ex_imm_src_o,
  output logic              mem_valid_o,
  output logic              mem_dm_wr_o,
  output logic [2:0]        mem_dm_ctrl_o,
  output logic              wb_valid_o,
  output logic              wb_ru_wr_o,
  output logic [1:0]        wb_wr_src_o,
  output logic [REG_AW-1:0] wb_rd_o
);

  localparam int STAGES = 3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] WS_LOAD = 2'b01;

  typedef struct packed {
    logic              asrc;
    logic              bsrc;
    logic [4:0]        alu_op;
    logic [4:0]        br_op;
    logic [2:0]        imm_src;
    logic              dm_wr;
    logic [2:0]        dm_ctrl;
    logic              ru_wr;
    logic [1:0]        wr_src;
    logic [REG_AW-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic              dm_wr;
    logic [2:0]        dm_ctrl;
    logic              ru_wr;
    logic [1:0]        wr_src;
    logic [REG_AW-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic              ru_wr;
    logic [1:0]        wr_src;
    logic [REG_AW-1:0] rd;
  } wb_t;

  ex_t               dec, ex_nxt;
  logic              dec_ill;
  ex_t               id_ex;
  mem_t              ex_mem;
  wb_t               mem_wb;
  logic              ill_q;
  logic              vld_in, ill_nxt, ins_ok;
  logic [STAGES:1]   vld_pipe;
  logic              hit_ex, hit_mem;

  always_comb begin
    dec     = '0;
    dec_ill = 1'b0;
    dec.rd  = rd_i;
    case (opcode_i)
      OP_R: begin
        if (funct7_i == 7'b0000001) begin
`ifdef CTRL_MEXT_EN
          dec.alu_op = {2'b10, funct3_i};
          dec.ru_wr  = 1'b1;
`else
          dec_ill = 1'b1;
`endif
        end else begin
          dec.alu_op = {1'b0, funct7_i[5], funct3_i};
          dec.ru_wr  = 1'b1;
        end
      end
      OP_IMM: begin
        // funct7[5] only distinguishes shifts (SRLI/SRAI); elsewhere it is immediate bits
        dec.alu_op = {1'b0, (funct3_i == 3'b001 || funct3_i == 3'b101) & funct7_i[5], funct3_i};
        dec.bsrc   = 1'b1;
        dec.ru_wr  = 1'b1;
      end
      OP_LOAD: begin
        dec.dm_ctrl = funct3_i;
        dec.wr_src  = WS_LOAD;
        dec.ru_wr   = 1'b1;
      end
      OP_STORE: begin
        dec.dm_wr   = 1'b1;
        dec.dm_ctrl = funct3_i;
        dec.imm_src = 3'b001;
      end
      OP_BRANCH: begin
        dec.asrc    = 1'b1;
        dec.bsrc    = 1'b1;
        dec.br_op   = {2'b01, funct3_i};
        dec.imm_src = 3'b101;
      end
      OP_JAL: begin
        dec.asrc    = 1'b1;
        dec.bsrc    = 1'b1;
        dec.br_op   = 5'b10000;
        dec.wr_src  = 2'b10;
        dec.ru_wr   = 1'b1;
        dec.imm_src = 3'b110;
      end
      OP_JALR: begin
        dec.bsrc   = 1'b1;
        dec.br_op  = 5'b10000;
        dec.wr_src = 2'b10;
        dec.ru_wr  = 1'b1;
      end
      OP_LUI: begin
        dec.bsrc    = 1'b1;
        dec.alu_op  = 5'b00111;
        dec.ru_wr   = 1'b1;
        dec.imm_src = 3'b010;
      end
      OP_AUIPC: begin
        dec.asrc    = 1'b1;
        dec.bsrc    = 1'b1;
        dec.ru_wr   = 1'b1;
        dec.imm_src = 3'b010;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) dec = '0;
  end

  // A load is identified downstream by its write-back source
  always_comb begin
    hit_ex  = vld_pipe[1] && (id_ex.wr_src == WS_LOAD) && (id_ex.rd != '0) &&
              ((id_ex.rd == rs1_i) || (id_ex.rd == rs2_i));
    hit_mem = (LOAD_USE_DIST >= 2) && vld_pipe[2] && (ex_mem.wr_src == WS_LOAD) &&
              (ex_mem.rd != '0) && ((ex_mem.rd == rs1_i) || (ex_mem.rd == rs2_i));
  end

  assign load_use_stall_o = id_valid_i && (hit_ex || hit_mem);

  always_comb begin
    ins_ok  = id_valid_i && !flush_i && !load_use_stall_o;
    vld_in  = ins_ok && !dec_ill;
    ill_nxt = ins_ok && dec_ill;
    ex_nxt  = vld_in ? dec : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_ex    <= '0;
      ex_mem   <= '0;
      mem_wb   <= '0;
      ill_q    <= 1'b0;
    end else if (!stall_i) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], vld_in};
      id_ex    <= ex_nxt;
      ex_mem   <= '{dm_wr: id_ex.dm_wr, dm_ctrl: id_ex.dm_ctrl, ru_wr: id_ex.ru_wr,
                    wr_src: id_ex.wr_src, rd: id_ex.rd};
      mem_wb   <= '{ru_wr: ex_mem.ru_wr, wr_src: ex_mem.wr_src, rd: ex_mem.rd};
      ill_q    <= ill_nxt;
    end
  end

  assign illegal_o     = ill_q;
  assign ex_valid_o    = vld_pipe[1];
  assign ex_alua_src_o = id_ex.asrc;
  assign ex_alub_src_o = id_ex.bsrc;
  assign ex_alu_op_o   = id_ex.alu_op;
  assign ex_br_op_o    = id_ex.br_op;
  assign ex_imm_src_o  = id_ex.imm_src;
  assign mem_valid_o   = vld_pipe[2];
  assign mem_dm_wr_o   = ex_mem.dm_wr;
  assign mem_dm_ctrl_o = ex_mem.dm_ctrl;
  assign wb_valid_o    = vld_pipe[3];
  assign wb_ru_wr_o    = mem_wb.ru_wr;
  assign wb_wr_src_o   = mem_wb.wr_src;
  assign wb_rd_o       = mem_wb.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized + directed bench for ctrl_pipe against a stage-list reference model.
module tb_ctrl_pipe;
  localparam int AW   = 5;
  localparam int DIST = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [6:0] opcode_i = '0, funct7_i = '0;
  logic [2:0] funct3_i = '0;
  logic [AW-1:0] rd_i = '0, rs1_i = '0, rs2_i = '0;
  logic load_use_stall_o, illegal_o;
  logic ex_valid_o, ex_alua_src_o, ex_alub_src_o;
  logic [4:0] ex_alu_op_o, ex_br_op_o;
  logic [2:0] ex_imm_src_o, mem_dm_ctrl_o;
  logic mem_valid_o, mem_dm_wr_o, wb_valid_o, wb_ru_wr_o;
  logic [1:0] wb_wr_src_o;
  logic [AW-1:0] wb_rd_o;

  ctrl_pipe #(.REG_AW(AW), .LOAD_USE_DIST(DIST)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .opcode_i(opcode_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .stall_i(stall_i), .flush_i(flush_i), .load_use_stall_o(load_use_stall_o),
    .illegal_o(illegal_o), .ex_valid_o(ex_valid_o), .ex_alua_src_o(ex_alua_src_o),
    .ex_alub_src_o(ex_alub_src_o), .ex_alu_op_o(ex_alu_op_o), .ex_br_op_o(ex_br_op_o),
    .ex_imm_src_o(ex_imm_src_o), .mem_valid_o(mem_valid_o), .mem_dm_wr_o(mem_dm_wr_o),
    .mem_dm_ctrl_o(mem_dm_ctrl_o), .wb_valid_o(wb_valid_o), .wb_ru_wr_o(wb_ru_wr_o),
    .wb_wr_src_o(wb_wr_src_o), .wb_rd_o(wb_rd_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v, asrc, bsrc;
    logic [4:0] aluop, brop;
    logic [2:0] imm;
    logic dmwr;
    logic [2:0] dmc;
    logic ruwr;
    logic [1:0] wrs;
    logic [AW-1:0] rd;
    logic ld;
  } mw_t;

  mw_t  st [1:3];
  logic m_ill;
  int   checks = 0, errors = 0;
  int   lus_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction table
  function automatic mw_t mdec(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [AW-1:0] rd,
                               output logic legal);
    mw_t w = '0;
    legal = 1'b1;
    w.v = 1'b1; w.rd = rd;
    case (op)
      7'h33: if (f7 == 7'h01) begin
`ifdef CTRL_MEXT_EN
               w.aluop = {2'b10, f3}; w.ruwr = 1'b1;
`else
               legal = 1'b0;
`endif
             end else begin w.aluop = {1'b0, f7[5], f3}; w.ruwr = 1'b1; end
      7'h13: begin
               w.aluop = {1'b0, ((f3 == 3'd1) || (f3 == 3'd5)) ? f7[5] : 1'b0, f3};
               w.bsrc = 1'b1; w.ruwr = 1'b1;
             end
      7'h03: begin w.dmc = f3; w.wrs = 2'd1; w.ruwr = 1'b1; w.ld = 1'b1; end
      7'h23: begin w.dmwr = 1'b1; w.dmc = f3; w.imm = 3'd1; end
      7'h63: begin w.asrc = 1'b1; w.bsrc = 1'b1; w.brop = {2'b01, f3}; w.imm = 3'd5; end
      7'h6f: begin w.asrc = 1'b1; w.bsrc = 1'b1; w.brop = 5'd16; w.wrs = 2'd2;
                   w.ruwr = 1'b1; w.imm = 3'd6; end
      7'h67: begin w.bsrc = 1'b1; w.brop = 5'd16; w.wrs = 2'd2; w.ruwr = 1'b1; end
      7'h37: begin w.bsrc = 1'b1; w.aluop = 5'd7; w.ruwr = 1'b1; w.imm = 3'd2; end
      7'h17: begin w.asrc = 1'b1; w.bsrc = 1'b1; w.ruwr = 1'b1; w.imm = 3'd2; end
      default: legal = 1'b0;
    endcase
    if (!legal) w = '0;
    return w;
  endfunction

  function automatic logic mhaz();
    logic h = 1'b0;
    for (int s = 1; s <= DIST; s++)
      if (st[s].v && st[s].ld && st[s].rd != 0 && (st[s].rd == rs1_i || st[s].rd == rs2_i))
        h = 1'b1;
    return id_valid_i && h;
  endfunction

  task automatic mreset();
    for (int s = 1; s <= 3; s++) st[s] = '0;
    m_ill = 1'b0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_ex"}, {ex_valid_o, ex_alua_src_o, ex_alub_src_o, ex_alu_op_o, ex_br_op_o, ex_imm_src_o},
        {st[1].v, st[1].asrc, st[1].bsrc, st[1].aluop, st[1].brop, st[1].imm});
    chk({tag, "_ill"}, illegal_o, m_ill);
    chk({tag, "_mem"}, {mem_valid_o, mem_dm_wr_o, mem_dm_ctrl_o}, {st[2].v, st[2].dmwr, st[2].dmc});
    chk({tag, "_wb"}, {wb_valid_o, wb_ru_wr_o, wb_wr_src_o, wb_rd_o},
        {st[3].v, st[3].ruwr, st[3].wrs, st[3].rd});
  endtask

  // One cycle, entered and left on a falling edge
  task automatic cyc(input string tag, input logic v, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [AW-1:0] rd, input logic [AW-1:0] r1,
                     input logic [AW-1:0] r2, input logic stl, input logic fl);
    logic h, legal;
    mw_t w;
    id_valid_i = v; opcode_i = op; funct3_i = f3; funct7_i = f7;
    rd_i = rd; rs1_i = r1; rs2_i = r2; stall_i = stl; flush_i = fl;
    #1;
    h = mhaz();
    chk({tag, "_lus"}, load_use_stall_o, h);
    if (load_use_stall_o) lus_cnt++;
    w = mdec(op, f3, f7, rd, legal);
    @(posedge clk);
    if (!stl) begin
      st[3] = st[2]; st[2] = st[1];
      st[1] = (v && !fl && !h && legal) ? w : '0;
      m_ill = v && !fl && !h && !legal;
    end
    #1;
    chk_regs(tag);
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc("nop", 1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  logic [6:0] ops [0:9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7f};
  logic [6:0] f7s [0:2] = '{7'h00, 7'h20, 7'h01};

  task automatic rnd_cycle();
    logic [6:0] op, f7;
    op = ops[$urandom_range(0, 9)];
    f7 = f7s[$urandom_range(0, 2)];
    cyc("rnd", $urandom_range(0, 99) < 85, op, 3'($urandom), f7, 5'($urandom_range(0, 3)),
        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
        $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15);
  endtask

  initial begin
    mreset();
    lus_cnt = 0;
    repeat (2) @(negedge clk);
    chk_regs("reset");
    chk("reset_lus", load_use_stall_o, 1'b0);
    rst_n = 1'b1;

    // add x3,x1,x2 ; lui x5 ; sw x3,0(x1)
    cyc("add", 1, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 0, 0);
    chk("add_aluop", ex_alu_op_o, 5'b00000);
    cyc("lui", 1, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 0, 0);
    cyc("sw",  1, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd3, 0, 0);
    nop(1);
    chk("sw_mem", {mem_dm_wr_o, mem_dm_ctrl_o}, 4'b1010);
    chk("lui_wb", {wb_valid_o, wb_ru_wr_o, wb_rd_o}, {2'b11, 5'd5});
    nop(2);

    // lw x6 then add x7,x6,x1 held in ID while stalled
    lus_cnt = 0;
    cyc("lw",  1, 7'h03, 3'd2, 7'h00, 5'd6, 5'd1, 5'd0, 0, 0);
    for (int i = 0; i < DIST + 1; i++)
      cyc("lu_add", 1, 7'h33, 3'd0, 7'h00, 5'd7, 5'd6, 5'd1, 0, 0);
    chk("lu_count", lus_cnt, DIST);
    nop(3);
    lus_cnt = 0;
    cyc("lw0", 1, 7'h03, 3'd2, 7'h00, 5'd0, 5'd1, 5'd0, 0, 0);
    cyc("use0", 1, 7'h33, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 0, 0);
    chk("lw_x0", lus_cnt, 0);
    nop(3);

    // flush with beq in ID while an older op sits in EX
    cyc("addi", 1, 7'h13, 3'd0, 7'h00, 5'd4, 5'd1, 5'd0, 0, 0);
    cyc("beqfl", 1, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 0, 1);
    chk("flush_ex", ex_valid_o, 1'b0);
    chk("flush_mem", mem_valid_o, 1'b1);

    // stall+flush for 3 cycles, then flush acts
    cyc("pre", 1, 7'h6f, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("stl", 1, 7'h63, 3'd1, 7'h00, 5'd0, 5'd1, 5'd2, 1, 1);
    chk("stall_ex", ex_br_op_o, 5'b10000);
    cyc("rel", 1, 7'h63, 3'd1, 7'h00, 5'd0, 5'd1, 5'd2, 0, 1);

    // illegal opcode and M-extension encoding
    cyc("bad", 1, 7'h7f, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 0, 0);
    chk("bad_ill", {illegal_o, ex_valid_o, ex_alu_op_o}, {2'b10, 5'd0});
    cyc("mul", 1, 7'h33, 3'd4, 7'h01, 5'd2, 5'd1, 5'd1, 0, 0);
`ifdef CTRL_MEXT_EN
    chk("mext", {illegal_o, ex_alu_op_o}, {1'b0, 5'b10100});
`else
    chk("mext", {illegal_o, ex_valid_o}, 2'b10);
`endif
    cyc("adv", 0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 0, 0);
    chk("ill_clear", illegal_o, 1'b0);

    repeat (300) rnd_cycle();

    // async reset mid-stream, no clock edge
    cyc("f1", 1, 7'h33, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 0, 0);
    cyc("f2", 1, 7'h37, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 0, 0);
    cyc("f3", 1, 7'h17, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 0, 0);
    id_valid_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    mreset();
    chk_regs("arst");
    #1 rst_n = 1'b1;
    @(negedge clk);

    repeat (300) rnd_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined successor to the single-cycle RV32I control decoder.
- Decodes the ID-stage instruction fields into a control word, then carries that word through ID/EX, EX/MEM and MEM/WB registers.
- Inserts bubbles for load-use hazards, external stalls and branch flushes.
- Sits between the IF/ID register and the datapath; each pipeline stage reads its control slice from this block.

Parameters:
- REG_AW, 5, register-address width (4 for RV32E).
- LOAD_USE_DIST, 1, number of stages after ID in which a load result is unavailable; legal values 1 (check EX only) or 2 (check EX and MEM).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid_i  in  1  ID-stage instruction valid.
- opcode_i  in  7  instruction opcode.
- funct3_i  in  3  instruction funct3.
- funct7_i  in  7  instruction funct7.
- rd_i / rs1_i / rs2_i  in  REG_AW each  register fields.
- stall_i  in  1  global freeze (e.g. memory wait).
- flush_i  in  1  squash the ID instruction (taken branch/jump).
- load_use_stall_o  out  1  combinational; hold PC and IF/ID.
- illegal_o  out  1  registered; the EX-stage instruction was undecodable.
- ex_valid_o  out  1  EX-stage valid.
- ex_alua_src_o  out  1  EX ALU operand-A source.
- ex_alub_src_o  out  1  EX ALU operand-B source.
- ex_alu_op_o  out  5  EX ALU operation.
- ex_br_op_o  out  5  EX branch operation.
- ex_imm_src_o  out  3  EX immediate format.
- mem_valid_o  out  1  MEM-stage valid.
- mem_dm_wr_o  out  1  MEM data-memory write enable.
- mem_dm_ctrl_o  out  3  MEM data-memory access control.
- wb_valid_o  out  1  WB-stage valid.
- wb_ru_wr_o  out  1  WB register-file write enable.
- wb_wr_src_o  out  2  WB write-data source.
- wb_rd_o  out  REG_AW  WB destination register.

Behaviour:
- Decode (combinational, ID stage), ALUOp is {0, funct7[5], funct3}:
  - R-type: ALUOp as above; RUWr=1; WrSrc=00.
  - OP-IMM: ALUOp as above, with funct7[5] used only for funct3 001/101 (otherwise 0); ALUBSrc=1; RUWr=1.
  - LOAD: DMCtrl=funct3; WrSrc=01; RUWr=1.
  - STORE: DMWr=1; DMCtrl=funct3; ImmSrc=001.
  - BRANCH: ASrc=BSrc=1; BrOp={01, funct3}; ImmSrc=101.
  - JAL: ASrc=BSrc=1; BrOp=10000; WrSrc=10; RUWr=1; ImmSrc=110.
  - JALR: BSrc=1; BrOp=10000; WrSrc=10; RUWr=1.
  - LUI: BSrc=1; ALUOp=00111; RUWr=1; ImmSrc=010.
  - AUIPC: ASrc=BSrc=1; RUWr=1; ImmSrc=010.
  - Any other opcode: bubble word, with the illegal bit set.
- Bubble word: all control outputs 0, valid 0, rd 0.
- Every output is registered except load_use_stall_o. Reset drives all registered outputs and valids to 0, immediately and asynchronously.
- Latency: an ID instruction appears on the EX outputs 1 cycle later, MEM outputs 2 cycles later and WB outputs 3 cycles later.
- Load-use hazard: load_use_stall_o=1 when id_valid_i, and EX holds a valid LOAD with rd≠0 matching rs1_i or rs2_i. With LOAD_USE_DIST=2, a matching valid LOAD in MEM also triggers it.
- Register update priority, per cycle:
  1. stall_i=1: all stage registers hold, flush_i is ignored, and the upstream holds flush_i.
  2. else flush_i=1: ID/EX loads a bubble; EX/MEM and MEM/WB advance.
  3. else load_use_stall_o=1: ID/EX loads a bubble; later stages advance.
  4. else all stages advance; ID/EX loads the decoded word if id_valid_i, otherwise a bubble.
- flush_i and a load-use hit in the same cycle: the bubble is inserted once; load_use_stall_o still asserts that cycle.
- rd=0 never causes a hazard; x0 writes propagate with RUWr as decoded.
- illegal_o travels with the EX-stage word and clears on the next advance.

Optional Feature:
- Macro: CTRL_MEXT_EN.
- Defined: an R-type instruction with funct7=0000001 decodes to ALUOp={10, funct3} (MUL/DIV family) with RUWr=1.
- Undefined: that encoding is treated as illegal and becomes a bubble with illegal_o=1.

Test Plan:
- Reset mid-stream: pulse rst_n low with three instructions in flight → all valids and controls read 0 immediately, with no clock edge needed.
- Sequence add x3,x1,x2 then lui x5 then sw → EX ALUOp=00000 on cycle 1; LUI at WB has RUWr=1 on cycle 4; sw at MEM has DMWr=1, DMCtrl=010.
- lw x6 followed by add x7,x6,x1 → load_use_stall_o=1 for exactly 1 cycle (2 cycles with LOAD_USE_DIST=2); one EX bubble; add reaches WB 1 cycle late. A lw to x0 causes no stall.
- flush_i=1 together with a valid beq in ID → EX valid=0 next cycle; the older instruction in EX still advances to MEM.
- stall_i=1 for 3 cycles with flush_i=1 → all outputs frozen and no bubble inserted; after release, flush acts on the next cycle.
- Opcode 1111111 → illegal_o=1 and all EX controls 0. funct7=0000001, funct3=100 → ALUOp=10100 with CTRL_MEXT_EN defined, illegal without it.
